// File: rtl/bdi_firstbase_compressor_pkg.sv
// Shared definitions for the fixed-first-base BDI compressor and decompressor:
// CoN codes, widths, packed-word field offsets and the compressed length table.
package bdi_pkg;

  localparam int LINE_W = 256;
  localparam int WORD_W = 260;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  localparam logic [3:0] CON_ZERO   = 4'd0;
  localparam logic [3:0] CON_REP8   = 4'd1;
  localparam logic [3:0] CON_B8D1   = 4'd2;
  localparam logic [3:0] CON_B8D2   = 4'd3;
  localparam logic [3:0] CON_B8D4   = 4'd4;
  localparam logic [3:0] CON_B4D1   = 4'd5;
  localparam logic [3:0] CON_B4D2   = 4'd6;
  localparam logic [3:0] CON_B2D1   = 4'd7;
  localparam logic [3:0] CON_UNCOMP = 4'd15;

  localparam int REP_OFF          = 4;
  localparam int UNC_OFF          = 4;
  localparam int B8_FLAG_OFF      = 4;
  localparam int B8_BASE_OFF      = 8;
  localparam int B8_DELTA_OFF     = 72;
  localparam int B4_FLAG_OFF      = 4;
  localparam int B4_BASE_OFF      = 12;
  localparam int B4_DELTA_OFF     = 44;
  localparam int B2_FLAG_OFF      = 4;
  localparam int B2_SEG0_FLAG_BIT = 19;
  localparam int B2_BASE_OFF      = 20;
  localparam int B2_DELTA_OFF     = 36;

  // Fields listed in encoding priority order.
  typedef struct packed {
    logic zero;
    logic rep;
    logic b8d1;
    logic b4d1;
    logic b8d2;
    logic b2d1;
    logic b4d2;
    logic b8d4;
  } fit_t;

  typedef struct packed {
    logic [3:0]        f8_1;
    logic [3:0]        f8_2;
    logic [3:0]        f8_4;
    logic [7:0]        f4_1;
    logic [7:0]        f4_2;
    logic [15:0]       f2_1;
    logic [3:0][7:0]   d8_1;
    logic [3:0][15:0]  d8_2;
    logic [3:0][31:0]  d8_4;
    logic [7:0][7:0]   d4_1;
    logic [7:0][15:0]  d4_2;
    logic [15:0][7:0]  d2_1;
  } delta_t;

  function automatic logic [LEN_W-1:0] con_len(input logic [3:0] con);
    logic [LEN_W-1:0] len;
    case (con)
      CON_REP8: len = 5'd8;
      CON_B8D1: len = 5'd12;
      CON_B8D2: len = 5'd16;
      CON_B8D4: len = 5'd24;
      CON_B4D1: len = 5'd12;
      CON_B4D2: len = 5'd20;
      CON_B2D1: len = 5'd18;
      default:  len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/bdi_firstbase_compressor_delta_fit.sv
// Per-segment delta test modulo W: flag=1 when v-base fits in K bytes, else flag=0 when
// base-v fits; o_fit low when neither does. Purely combinational.
module bdi_delta_fit #(
  parameter int W = 64,
  parameter int K = 1
) (
  input  logic [W-1:0]   i_base,
  input  logic [W-1:0]   i_v,
  output logic           o_fit,
  output logic           o_flag,
  output logic [8*K-1:0] o_delta
);

  logic [W-1:0] w_up;
  logic [W-1:0] w_dn;
  logic         w_up_ok;
  logic         w_dn_ok;

  assign w_up    = i_v - i_base;
  assign w_dn    = i_base - i_v;
  assign w_up_ok = (w_up[W-1:8*K] == '0);
  assign w_dn_ok = (w_dn[W-1:8*K] == '0);

  assign o_fit   = w_up_ok || w_dn_ok;
  assign o_flag  = w_up_ok;
  assign o_delta = w_up_ok ? w_up[8*K-1:0] : w_dn[8*K-1:0];

endmodule

// File: rtl/bdi_firstbase_compressor.sv
// Fixed-first-base BDI line compressor: capture, fit/delta, select+pack; out_valid 2 cycles after accept.
// Single global enable (!out_valid || out_ready) stalls every stage; in_ready mirrors it.
module bdi_firstbase_compressor
  import bdi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic [ADDR_W-1:0] out_addr
);

  logic              w_en;
  logic              r_s0_vld;
  logic [LINE_W-1:0] r_s0_line;
  logic              r_s1_vld;
  logic [LINE_W-1:0] r_s1_line;
  fit_t              r_s1_fit;
  delta_t            r_s1_dlt;
  fit_t              w_fit;
  delta_t            w_dlt;
  logic [3:0]        w_con;
  logic [WORD_W-1:0] w_word;
  logic              r_out_vld;
  logic [WORD_W-1:0] r_out_dat;
  logic [LEN_W-1:0]  r_out_len;
  logic [ADDR_W-1:0] r_out_addr;

  logic [3:0]        w_ok8_1, w_ok8_2, w_ok8_4, w_f8_1, w_f8_2, w_f8_4;
  logic [7:0]        w_ok4_1, w_ok4_2, w_f4_1, w_f4_2;
  logic [15:0]       w_ok2_1, w_f2_1;
  logic [3:0][7:0]   w_d8_1;
  logic [3:0][15:0]  w_d8_2;
  logic [3:0][31:0]  w_d8_4;
  logic [7:0][7:0]   w_d4_1;
  logic [7:0][15:0]  w_d4_2;
  logic [15:0][7:0]  w_d2_1;

  assign w_en      = !r_out_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_len   = r_out_len;
  assign out_addr  = r_out_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_vld  <= 1'b0;
      r_s0_line <= '0;
    end else if (w_en) begin
      r_s0_vld <= in_valid;
      if (in_valid) r_s0_line <= in_line;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_b8
    bdi_delta_fit #(.W(64), .K(1)) u_k1 (.i_base(r_s0_line[63:0]), .i_v(r_s0_line[64*i +: 64]),
      .o_fit(w_ok8_1[i]), .o_flag(w_f8_1[i]), .o_delta(w_d8_1[i]));
    bdi_delta_fit #(.W(64), .K(2)) u_k2 (.i_base(r_s0_line[63:0]), .i_v(r_s0_line[64*i +: 64]),
      .o_fit(w_ok8_2[i]), .o_flag(w_f8_2[i]), .o_delta(w_d8_2[i]));
    bdi_delta_fit #(.W(64), .K(4)) u_k4 (.i_base(r_s0_line[63:0]), .i_v(r_s0_line[64*i +: 64]),
      .o_fit(w_ok8_4[i]), .o_flag(w_f8_4[i]), .o_delta(w_d8_4[i]));
  end

  for (genvar i = 0; i < 8; i++) begin : g_b4
    bdi_delta_fit #(.W(32), .K(1)) u_k1 (.i_base(r_s0_line[31:0]), .i_v(r_s0_line[32*i +: 32]),
      .o_fit(w_ok4_1[i]), .o_flag(w_f4_1[i]), .o_delta(w_d4_1[i]));
    bdi_delta_fit #(.W(32), .K(2)) u_k2 (.i_base(r_s0_line[31:0]), .i_v(r_s0_line[32*i +: 32]),
      .o_fit(w_ok4_2[i]), .o_flag(w_f4_2[i]), .o_delta(w_d4_2[i]));
  end

  for (genvar i = 0; i < 16; i++) begin : g_b2
    bdi_delta_fit #(.W(16), .K(1)) u_k1 (.i_base(r_s0_line[15:0]), .i_v(r_s0_line[16*i +: 16]),
      .o_fit(w_ok2_1[i]), .o_flag(w_f2_1[i]), .o_delta(w_d2_1[i]));
  end

  always_comb begin
    w_fit      = '0;
    w_fit.zero = (r_s0_line == '0);
    w_fit.rep  = (r_s0_line == {4{r_s0_line[63:0]}});
    w_fit.b8d1 = &w_ok8_1;
    w_fit.b4d1 = &w_ok4_1;
    w_fit.b8d2 = &w_ok8_2;
    w_fit.b2d1 = &w_ok2_1;
    w_fit.b4d2 = &w_ok4_2;
    w_fit.b8d4 = &w_ok8_4;
  end

  always_comb begin
    w_dlt      = '0;
    w_dlt.f8_1 = w_f8_1;
    w_dlt.f8_2 = w_f8_2;
    w_dlt.f8_4 = w_f8_4;
    w_dlt.f4_1 = w_f4_1;
    w_dlt.f4_2 = w_f4_2;
    w_dlt.f2_1 = w_f2_1;
    w_dlt.d8_1 = w_d8_1;
    w_dlt.d8_2 = w_d8_2;
    w_dlt.d8_4 = w_d8_4;
    w_dlt.d4_1 = w_d4_1;
    w_dlt.d4_2 = w_d4_2;
    w_dlt.d2_1 = w_d2_1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_line <= '0;
      r_s1_fit  <= '0;
      r_s1_dlt  <= '0;
    end else if (w_en) begin
      r_s1_vld <= r_s0_vld;
      if (r_s0_vld) begin
        r_s1_line <= r_s0_line;
        r_s1_fit  <= w_fit;
        r_s1_dlt  <= w_dlt;
      end
    end
  end

  always_comb begin
    w_con = CON_UNCOMP;
    if      (r_s1_fit.zero) w_con = CON_ZERO;
    else if (r_s1_fit.rep)  w_con = CON_REP8;
    else if (r_s1_fit.b8d1) w_con = CON_B8D1;
    else if (r_s1_fit.b4d1) w_con = CON_B4D1;
    else if (r_s1_fit.b8d2) w_con = CON_B8D2;
    else if (r_s1_fit.b2d1) w_con = CON_B2D1;
    else if (r_s1_fit.b4d2) w_con = CON_B4D2;
    else if (r_s1_fit.b8d4) w_con = CON_B8D4;
  end

  always_comb begin
    w_word = '0;
    case (w_con)
      CON_ZERO: w_word = '0;
      CON_REP8: w_word[REP_OFF +: 64] = r_s1_line[63:0];
      CON_B8D1: begin
        w_word[B8_FLAG_OFF +: 4]  = r_s1_dlt.f8_1;
        w_word[B8_BASE_OFF +: 64] = r_s1_line[63:0];
        for (int i = 0; i < 4; i++) w_word[B8_DELTA_OFF + 8*i +: 8] = r_s1_dlt.d8_1[i];
      end
      CON_B8D2: begin
        w_word[B8_FLAG_OFF +: 4]  = r_s1_dlt.f8_2;
        w_word[B8_BASE_OFF +: 64] = r_s1_line[63:0];
        for (int i = 0; i < 4; i++) w_word[B8_DELTA_OFF + 16*i +: 16] = r_s1_dlt.d8_2[i];
      end
      CON_B8D4: begin
        w_word[B8_FLAG_OFF +: 4]  = r_s1_dlt.f8_4;
        w_word[B8_BASE_OFF +: 64] = r_s1_line[63:0];
        for (int i = 0; i < 4; i++) w_word[B8_DELTA_OFF + 32*i +: 32] = r_s1_dlt.d8_4[i];
      end
      CON_B4D1: begin
        w_word[B4_FLAG_OFF +: 8]  = r_s1_dlt.f4_1;
        w_word[B4_BASE_OFF +: 32] = r_s1_line[31:0];
        for (int i = 0; i < 8; i++) w_word[B4_DELTA_OFF + 8*i +: 8] = r_s1_dlt.d4_1[i];
      end
      CON_B4D2: begin
        w_word[B4_FLAG_OFF +: 8]  = r_s1_dlt.f4_2;
        w_word[B4_BASE_OFF +: 32] = r_s1_line[31:0];
        for (int i = 0; i < 8; i++) w_word[B4_DELTA_OFF + 16*i +: 16] = r_s1_dlt.d4_2[i];
      end
      CON_B2D1: begin
        // The decompressor expects segment 0's flag rotated to the top flag bit.
        for (int j = 1; j < 16; j++) w_word[B2_FLAG_OFF + j - 1] = r_s1_dlt.f2_1[j];
        w_word[B2_SEG0_FLAG_BIT]  = r_s1_dlt.f2_1[0];
        w_word[B2_BASE_OFF +: 16] = r_s1_line[15:0];
        for (int j = 0; j < 16; j++) w_word[B2_DELTA_OFF + 8*j +: 8] = r_s1_dlt.d2_1[j];
      end
      default: w_word[UNC_OFF +: LINE_W] = r_s1_line;
    endcase
    w_word[3:0] = w_con;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_len  <= '0;
      r_out_addr <= '0;
    end else begin
      if (w_en) begin
        r_out_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_out_dat <= w_word;
          r_out_len <= con_len(w_con);
        end
      end
      if (r_out_vld && out_ready) r_out_addr <= r_out_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_bdi_firstbase_compressor.sv
// Scoreboarded bench for the BDI first-base compressor: directed vectors, a
// backpressured 18-line stream, reset with lines in flight, then random traffic.
module tb_bdi_firstbase_compressor;

  typedef struct packed {
    logic [259:0] d;
    logic [4:0]   len;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_line = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [259:0] out_data;
  logic [4:0]   out_len;
  logic [3:0]   out_addr;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [3:0]   exp_addr = '0;
  bit           stall_seen = 1'b0;
  logic [259:0] held_d;
  logic [4:0]   held_len;
  logic [3:0]   held_addr;
  exp_t         e, m;
  logic [255:0] l, la, lb;
  bit           done;

  bdi_firstbase_compressor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: try each encoding in priority order from the segment rules directly.
  function automatic bit try_enc(input logic [255:0] ln, input int bsz, input int k,
                                 input logic [3:0] con, output logic [259:0] w);
    int n, doff;
    logic [63:0] mask, lim, base, v, up, dn, d;
    logic [255:0] sh;
    logic f;
    n    = 32 / bsz;
    doff = 4 + n + 8 * bsz;
    mask = (bsz == 8) ? '1 : ((64'd1 << (8 * bsz)) - 64'd1);
    lim  = 64'd1 << (8 * k);
    base = ln[63:0] & mask;
    w = '0;
    w[3:0] = con;
    for (int b = 0; b < 8 * bsz; b++) w[4 + n + b] = base[b];
    for (int i = 0; i < n; i++) begin
      sh = ln >> (8 * bsz * i);
      v  = sh[63:0] & mask;
      up = (v - base) & mask;
      dn = (base - v) & mask;
      if (up < lim) begin f = 1'b1; d = up; end
      else if (dn < lim) begin f = 1'b0; d = dn; end
      else return 1'b0;
      w[(n == 16) ? ((i == 0) ? 19 : 3 + i) : 4 + i] = f;
      for (int b = 0; b < 8 * k; b++) w[doff + 8 * k * i + b] = d[b];
    end
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic [255:0] ln);
    exp_t r;
    logic [259:0] w;
    int bs[6];
    int ks[6];
    logic [3:0] cs[6];
    bs = '{8, 4, 8, 2, 4, 8};
    ks = '{1, 1, 2, 1, 2, 4};
    cs = '{4'd2, 4'd5, 4'd3, 4'd7, 4'd6, 4'd4};
    r.d = '0;
    r.len = '0;
    if (ln == '0) return r;
    if (ln[255:192] == ln[63:0] && ln[191:128] == ln[63:0] && ln[127:64] == ln[63:0]) begin
      r.d[67:4] = ln[63:0];
      r.d[3:0]  = 4'd1;
      r.len     = 5'd8;
      return r;
    end
    for (int p = 0; p < 6; p++) begin
      if (try_enc(ln, bs[p], ks[p], cs[p], w)) begin
        r.d   = w;
        r.len = 5'(bs[p] + (32 / bs[p]) * ks[p]);
        return r;
      end
    end
    r.d = {ln, 4'hF};
    return r;
  endfunction

  function automatic logic [255:0] gen_line();
    logic [255:0] ln;
    logic [63:0] base, mask, lim, d, v;
    int bsz, k, n, kind, sel;
    kind = $urandom_range(0, 9);
    sel  = $urandom_range(0, 2);
    bsz  = (sel == 0) ? 2 : (sel == 1) ? 4 : 8;
    k    = 1 << $urandom_range(0, (bsz == 2) ? 0 : (bsz == 4) ? 1 : 2);
    ln   = '0;
    if (kind == 0) return ln;
    if (kind == 1) begin
      v = {$urandom, $urandom};
      return {4{v}};
    end
    if (kind == 9) begin
      for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
      return ln;
    end
    mask = (bsz == 8) ? '1 : ((64'd1 << (8 * bsz)) - 64'd1);
    lim  = 64'd1 << (8 * k);
    base = {$urandom, $urandom} & mask;
    n    = 32 / bsz;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0: d = lim - 64'd1;
        1: d = lim;
        default: d = {$urandom, $urandom} % lim;
      endcase
      if (i == 0) v = base;
      else if ($urandom_range(0, 1) == 1) v = base + d;
      else v = base - d;
      ln = ln | ((256'(v & mask)) << (8 * bsz * i));
    end
    return ln;
  endfunction

  task automatic send(input logic [255:0] ln, input exp_t ex);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_line  = ln;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 expected=1");
    end else begin
      q.push_back(ex);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_addr   = '0;
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", 260'(out_valid), 260'(1));
        chk("hold_data", out_data, held_d);
        chk("hold_len", 260'(out_len), 260'(held_len));
        chk("hold_addr", 260'(out_addr), 260'(held_addr));
      end
      stall_seen = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output got=%0h expected=none", out_data);
        end else begin
          m = q.pop_front();
          chk("out_data", out_data, m.d);
          chk("out_len", 260'(out_len), 260'(m.len));
          chk("out_addr", 260'(out_addr), 260'(exp_addr));
          exp_addr = exp_addr + 4'd1;
        end
      end else if (out_valid) begin
        stall_seen = 1'b1;
        held_d     = out_data;
        held_len   = out_len;
        held_addr  = out_addr;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 260'(out_valid), 260'(0));
    chk("rst_out_data", out_data, 260'(0));
    chk("rst_out_len", 260'(out_len), 260'(0));
    chk("rst_out_addr", 260'(out_addr), 260'(0));
    chk("rst_in_ready", 260'(in_ready), 260'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    l = '0;
    e.d = '0;
    e.len = 5'd0;
    send(l, e);
    chk("lat_cycle0", 260'(out_valid), 260'(0));
    @(posedge clk);
    #1;
    chk("lat_cycle1", 260'(out_valid), 260'(0));
    @(posedge clk);
    #1;
    chk("lat_cycle2", 260'(out_valid), 260'(1));

    l = {4{64'hDEADBEEF_01234567}};
    e.d = '0;
    e.d[3:0] = 4'd1;
    e.d[67:4] = 64'hDEADBEEF_01234567;
    e.len = 5'd8;
    send(l, e);

    l = {64'h1000, 64'h0FFE, 64'h1005, 64'h1000};
    e.d = '0;
    e.d[3:0] = 4'd2;
    e.d[7:4] = 4'hB;
    e.d[71:8] = 64'h1000;
    e.d[87:80] = 8'h05;
    e.d[95:88] = 8'h02;
    e.len = 5'd12;
    send(l, e);

    l = {16{16'h0100}};
    l[255:240] = 16'h0180;
    e.d = '0;
    e.d[3:0] = 4'd7;
    e.d[19:4] = 16'hFFFF;
    e.d[35:20] = 16'h0100;
    e.d[163:156] = 8'h80;
    e.len = 5'd18;
    send(l, e);

    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    e.d = {l, 4'hF};
    e.len = 5'd0;
    send(l, e);
    drain();

    la = gen_line();
    lb = gen_line();
    send(la, model(la));
    send(lb, model(lb));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 260'(out_valid), 260'(0));
    chk("midrst_out_data", out_data, 260'(0));
    chk("midrst_out_len", 260'(out_len), 260'(0));
    chk("midrst_out_addr", 260'(out_addr), 260'(0));
    chk("midrst_in_ready", 260'(in_ready), 260'(1));
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_flushed", 260'(out_valid), 260'(0));
    end

    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          l = gen_line();
          send(l, model(l));
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          l = gen_line();
          send(l, model(l));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
